// File: rtl/mfcc_frame_reader.sv
// Read-side consumer of the MFCC output FIFO: once a full frame is available it pops
// DEPTH words one at a time, streams them out with index/last, and reports the frame sum and count.
module mfcc_frame_reader #(
  parameter int DEPTH  = 20,
  parameter int DATA_W = 32,
  parameter int FCNT_W = 16,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              rdclk,
  input  logic              rd_rstn,
  input  logic              en,
  input  logic              fifo_full,
  output logic              fifo_rden,
  input  logic [DATA_W-1:0] fifo_pop_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [IDX_W-1:0]  m_idx,
  output logic              m_last,
  output logic              busy,
  output logic              sum_valid,
  output logic [DATA_W-1:0] frame_sum,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_CAPT = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic                rden_q, rden_d;
  logic                busy_q, busy_d;
  logic                sum_valid_q, sum_valid_d;
  logic [DATA_W-1:0]   frame_sum_q, frame_sum_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  // Next-state and datapath decode. The strobe-style outputs (rden, busy, sum_valid)
  // are registered from state_d so they line up exactly with the state they describe.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    frame_sum_d = frame_sum_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (en && fifo_full) begin
          state_d = S_POP;
          idx_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        m_data_d  = fifo_pop_data;
        acc_d     = acc_q + fifo_pop_data;
        m_valid_d = 1'b1;
        m_last_d  = (idx_q == LAST_IDX);
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        // m_valid is always high here, so m_ready alone completes the handshake
        if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d     = S_DONE;
            frame_sum_d = acc_q;
            frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_POP;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rden_d      = (state_d == S_POP);
    busy_d      = (state_d != S_IDLE);
    sum_valid_d = (state_d == S_DONE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge rdclk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      rden_q      <= 1'b0;
      busy_q      <= 1'b0;
      sum_valid_q <= 1'b0;
      frame_sum_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      rden_q      <= rden_d;
      busy_q      <= busy_d;
      sum_valid_q <= sum_valid_d;
      frame_sum_q <= frame_sum_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign fifo_rden = rden_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_idx     = idx_q;
  assign m_last    = m_last_q;
  assign busy      = busy_q;
  assign sum_valid = sum_valid_q;
  assign frame_sum = frame_sum_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mfcc_frame_reader.sv
// Bench for mfcc_frame_reader: queue-based FIFO and stream model, per-cycle checker,
// directed scenarios plus randomized frames. A second instance with FCNT_W=2 checks counter wrap.
module tb_mfcc_frame_reader;
  localparam int DEPTH = 20;
  localparam int DW    = 32;
  localparam int FW    = 16;
  localparam int IW    = $clog2(DEPTH);

  logic          rdclk = 1'b0;
  logic          rd_rstn = 1'b0;
  logic          en = 1'b0;
  logic          fifo_full = 1'b0;
  logic          fifo_rden;
  logic [DW-1:0] fifo_pop_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_idx;
  logic          m_last;
  logic          busy;
  logic          sum_valid;
  logic [DW-1:0] frame_sum;
  logic [FW-1:0] frame_cnt;

  logic          s_fifo_rden, s_m_valid, s_m_last, s_busy, s_sum_valid;
  logic [DW-1:0] s_m_data, s_frame_sum;
  logic [IW-1:0] s_m_idx;
  logic [1:0]    s_frame_cnt;

  mfcc_frame_reader #(.DEPTH(DEPTH), .DATA_W(DW), .FCNT_W(FW)) dut (
    .rdclk(rdclk), .rd_rstn(rd_rstn), .en(en), .fifo_full(fifo_full),
    .fifo_rden(fifo_rden), .fifo_pop_data(fifo_pop_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
    .m_last(m_last), .busy(busy), .sum_valid(sum_valid),
    .frame_sum(frame_sum), .frame_cnt(frame_cnt)
  );

  mfcc_frame_reader #(.DEPTH(DEPTH), .DATA_W(DW), .FCNT_W(2)) dut_small (
    .rdclk(rdclk), .rd_rstn(rd_rstn), .en(en), .fifo_full(fifo_full),
    .fifo_rden(s_fifo_rden), .fifo_pop_data(fifo_pop_data),
    .m_valid(s_m_valid), .m_ready(m_ready), .m_data(s_m_data), .m_idx(s_m_idx),
    .m_last(s_m_last), .busy(s_busy), .sum_valid(s_sum_valid),
    .frame_sum(s_frame_sum), .frame_cnt(s_frame_cnt)
  );

  always #5 rdclk = ~rdclk;

  int tests = 0;
  int failures = 0;

  task automatic check(input bit ok, input string name,
                       input longint unsigned act, input longint unsigned exp);
    tests++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // FIFO model: pop on rden, data registered; full once a frame's worth is stored
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  bit            full_gate = 1'b1;

  always @(posedge rdclk) begin
    if (fifo_rden && fifo_q.size() > 0) fifo_pop_data <= fifo_q.pop_front();
    fifo_full <= full_gate && (fifo_q.size() >= DEPTH);
  end

  // Stream model state, owned by the checker
  int            cyc = 0;
  int            exp_idx = 0;
  int            rden_cnt = 0;
  int            rden_total = 0;
  int            exp_cnt = 0;
  int            n_sums = 0;
  int            t_first = 0;
  int            t_sum = 0;
  int            last_lat = 0;
  logic [DW-1:0] exp_sum = '0;
  logic [DW-1:0] last_sum = '0;
  bit            sum_due = 1'b0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic [IW-1:0] prev_idx;
  logic          prev_last;

  // Per-cycle compare against the model, sampled mid-cycle
  always @(negedge rdclk) begin
    int expc;
    cyc++;
    if (!rd_rstn) begin
      check(!fifo_rden && !m_valid && m_data == '0 && m_idx == '0 && !m_last && !busy &&
            !sum_valid && frame_sum == '0 && frame_cnt == '0 && s_frame_cnt == 2'd0,
            "reset_outputs", {m_valid, busy, sum_valid, fifo_rden}, 0);
      exp_idx = 0; rden_cnt = 0; exp_cnt = 0; exp_sum = '0; last_sum = '0;
      sum_due = 1'b0; prev_hold = 1'b0;
    end else begin
      if (fifo_rden) begin
        rden_cnt++;
        rden_total++;
        if (rden_cnt == 1) t_first = cyc;
        check(!m_valid, "rden_while_valid", m_valid, 0);
        check(rden_cnt <= DEPTH, "rden_per_frame", rden_cnt, DEPTH);
      end
      check(busy == (rden_cnt > 0), "busy", busy, rden_cnt > 0);
      check(sum_valid == sum_due, "sum_valid_timing", sum_valid, sum_due);
      if (prev_hold)
        check(m_valid && m_data == prev_data && m_idx == prev_idx && m_last == prev_last,
              "hold_stable", m_data, prev_data);
      if (m_valid) begin
        if (exp_q.size() > 0) check(m_data == exp_q[0], "m_data", m_data, exp_q[0]);
        else check(1'b0, "m_data_unexpected", m_data, 0);
        check(m_idx == IW'(exp_idx), "m_idx", m_idx, exp_idx);
        check(m_last == (exp_idx == DEPTH - 1), "m_last", m_last, exp_idx == DEPTH - 1);
      end else begin
        check(!m_last, "m_last_without_valid", m_last, 0);
      end

      expc = sum_valid ? exp_cnt + 1 : exp_cnt;
      check(frame_cnt == FW'(expc), "frame_cnt", frame_cnt, FW'(expc));
      check(s_frame_cnt == 2'(expc), "frame_cnt_small", s_frame_cnt, 2'(expc));
      check(s_fifo_rden == fifo_rden && s_sum_valid == sum_valid && s_m_valid == m_valid &&
            s_m_data == m_data && s_m_idx == m_idx && s_m_last == m_last && s_busy == busy &&
            s_frame_sum == frame_sum, "small_instance_stream", s_m_data, m_data);
      if (sum_valid) begin
        check(frame_sum == exp_sum, "frame_sum", frame_sum, exp_sum);
        check(rden_cnt == DEPTH, "rden_pulses", rden_cnt, DEPTH);
        last_sum = exp_sum; exp_cnt = expc; n_sums++;
        last_lat = cyc - t_first; t_sum = cyc;
        exp_sum = '0; exp_idx = 0; rden_cnt = 0;
      end else begin
        check(frame_sum == last_sum, "frame_sum_held", frame_sum, last_sum);
      end

      sum_due = 1'b0;
      prev_hold = 1'b0;
      if (m_valid && m_ready) begin
        if (exp_q.size() > 0) exp_sum = exp_sum + exp_q.pop_front();
        exp_idx++;
        sum_due = (exp_idx == DEPTH);
      end else if (m_valid) begin
        prev_hold = 1'b1; prev_data = m_data; prev_idx = m_idx; prev_last = m_last;
      end
    end
  end

  // kind 0: base+1..base+DEPTH, 1: all ones, 2: random
  task automatic load_frame(input int kind, input int base);
    logic [DW-1:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      case (kind)
        0:       w = DW'(base + i + 1);
        1:       w = 32'hFFFF_FFFF;
        default: w = $urandom;
      endcase
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  // mode 0: ready high, 1: 1-0-0-1 pattern, 2: random; en dropped at drop_at words
  task automatic run_frame(input int mode, input int drop_at);
    int start;
    int k;
    start = n_sums;
    k = 0;
    while (n_sums == start && k < 3000) begin
      @(posedge rdclk); #1;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 4 == 0) || (k % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (drop_at >= 0 && exp_idx >= drop_at) en = 1'b0;
      k++;
    end
    check(n_sums != start, "frame_timeout", k, 3000);
  endtask

  initial begin
    int rt0;
    int t_sum_a;
    int k;

    repeat (3) @(posedge rdclk);
    #1;
    check(!busy && !fifo_rden && frame_cnt == 16'd0 && frame_sum == 32'd0,
          "por_state", busy, 0);
    rd_rstn = 1'b1;

    // Basic frame 1..20
    en = 1'b1;
    load_frame(0, 0);
    run_frame(0, -1);
    check(frame_sum == 32'd210, "basic_sum", frame_sum, 210);
    check(frame_cnt == 16'd1, "basic_cnt", frame_cnt, 1);
    check(last_lat == 60, "basic_latency", last_lat + 1, 61);

    // Backpressure
    load_frame(0, 0);
    run_frame(1, -1);
    check(frame_sum == 32'd210, "bp_sum", frame_sum, 210);
    check(frame_cnt == 16'd2, "bp_cnt", frame_cnt, 2);

    // Enable gating
    en = 1'b0;
    m_ready = 1'b1;
    load_frame(0, 0);
    rt0 = rden_total;
    repeat (50) @(posedge rdclk);
    #1;
    check(fifo_full && !busy && rden_total == rt0, "gated_idle", rden_total - rt0, 0);
    en = 1'b1;
    @(negedge rdclk);
    check(!fifo_rden, "en_pop_not_early", fifo_rden, 0);
    @(negedge rdclk);
    check(fifo_rden, "en_pop_next_cycle", fifo_rden, 1);
    run_frame(0, 5);
    check(!en, "en_dropped", en, 0);
    check(frame_cnt == 16'd3 && frame_sum == 32'd210, "gated_frame_done", frame_cnt, 3);
    en = 1'b1;

    // Sum wrap; small counter wraps to 0 on this fourth frame
    load_frame(1, 0);
    run_frame(0, -1);
    check(frame_sum == 32'hFFFF_FFEC, "wrap_sum", frame_sum, 32'hFFFF_FFEC);
    check(last_lat == 60, "wrap_latency", last_lat + 1, 61);
    check(frame_cnt == 16'd4, "wrap_cnt", frame_cnt, 4);
    check(s_frame_cnt == 2'd0, "small_cnt_wrap", s_frame_cnt, 0);

    // Reset after the handshake of word 7
    load_frame(0, 0);
    k = 0;
    while (exp_idx < 7 && k < 500) begin
      @(posedge rdclk); #1;
      m_ready = 1'b1;
      k++;
    end
    check(exp_idx == 7, "reach_word7", exp_idx, 7);
    @(posedge rdclk); #1;
    rd_rstn = 1'b0;
    #1;
    check(!fifo_rden && !m_valid && m_data == '0 && m_idx == '0 && !m_last && !busy &&
          !sum_valid && frame_sum == '0 && frame_cnt == '0, "async_reset", frame_cnt, 0);
    fifo_q.delete();
    exp_q.delete();
    repeat (2) @(posedge rdclk);
    #1;
    rd_rstn = 1'b1;
    load_frame(0, 0);
    run_frame(2, -1);
    check(frame_cnt == 16'd1 && frame_sum == 32'd210, "after_reset_frame", frame_cnt, 1);

    // Back-to-back frames
    load_frame(0, 0);
    load_frame(0, 20);
    run_frame(0, -1);
    t_sum_a = t_sum;
    check(frame_sum == 32'd210, "b2b_first_sum", frame_sum, 210);
    run_frame(0, -1);
    check(frame_sum == 32'd610, "b2b_second_sum", frame_sum, 610);
    check(frame_cnt == 16'd3, "b2b_cnt", frame_cnt, 3);
    check(t_first - t_sum_a == 2, "b2b_restart", t_first - t_sum_a, 2);

    // Randomized frames
    for (int f = 0; f < 5; f++) begin
      repeat ($urandom_range(0, 4)) @(posedge rdclk);
      #1;
      load_frame(2, 0);
      run_frame(2, -1);
    end
    check(frame_cnt == 16'd8, "random_cnt", frame_cnt, 8);
    check(exp_q.size() == 0 && fifo_q.size() == 0, "queues_drained", exp_q.size(), 0);

    repeat (3) @(posedge rdclk);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
